// File: rtl/data_cache_if.sv
// data_cache_if: bundles the CPU MEM-stage handshake and the line-wide
// backing-memory bus of the data cache.
//   CPU side : is_input_valid/addr/mem_read/mem_write/din in,
//              is_ready/is_output_valid/dout/is_hit out
//   Mem side : mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in
// Modport slave is the cache; modport master is its environment
// (CPU stage plus memory model).
interface data_cache_if #(
  parameter int LINE_BITS = 128
);
  logic                 is_input_valid;
  logic [31:0]          addr;
  logic                 mem_read;
  logic                 mem_write;
  logic [31:0]          din;
  logic                 is_ready;
  logic                 is_output_valid;
  logic [31:0]          dout;
  logic                 is_hit;
  logic                 mem_req;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic                 mem_ack;
  logic [LINE_BITS-1:0] mem_rdata;

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din, mem_ack, mem_rdata,
    output is_ready, is_output_valid, dout, is_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din, mem_ack, mem_rdata,
    input  is_ready, is_output_valid, dout, is_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high
//   bus        : data_cache_if.slave (CPU request/response + line memory bus)
//   num_hits   : requests that hit on their first lookup (wraps)
//   num_misses : requests that missed on their first lookup (wraps)
// A miss on a dirty victim writes the victim back before refilling; after the
// refill the request is looked up again and completes as an ordinary hit.
module data_cache #(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 128
) (
  input  logic        clk,
  input  logic        reset,
  data_cache_if.slave bus,
  output logic [31:0] num_hits,
  output logic [31:0] num_misses
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       word;
    logic             wr;
    logic [31:0]      wdata;
  } req_t;

  state_t               state;
  req_t                 req;
  logic                 first;   // current COMPARE is the request's first lookup
  logic [NUM_SETS-1:0]  valid;
  logic [NUM_SETS-1:0]  dirty;
  logic [TAG_W-1:0]     tags [NUM_SETS];
  logic [LINE_BITS-1:0] data [NUM_SETS];

  logic        accept;
  logic        hit;
  logic        refill_done;
  logic [31:0] line_word;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.addr[1:0];
  assign bus.is_ready    = (state == IDLE);
  assign accept          = bus.is_input_valid & bus.is_ready & (bus.mem_read | bus.mem_write);
  assign hit             = valid[req.idx] && (tags[req.idx] == req.tag);
  assign line_word       = data[req.idx][{req.word, 5'd0} +: 32];
  assign refill_done     = (state == ALLOCATE) && bus.mem_req && bus.mem_ack;

  // Line storage carries no reset; only the valid/dirty bits are cleared.
  // Reset forces state to IDLE asynchronously, so no write can slip through.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      data[req.idx] <= bus.mem_rdata;
      tags[req.idx] <= req.tag;
    end else if (state == COMPARE && hit && req.wr) begin
      data[req.idx][{req.word, 5'd0} +: 32] <= req.wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      req                 <= '0;
      first               <= 1'b0;
      valid               <= '0;
      dirty               <= '0;
      bus.is_output_valid <= 1'b0;
      bus.is_hit          <= 1'b0;
      bus.dout            <= '0;
      bus.mem_req         <= 1'b0;
      bus.mem_we          <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
      num_hits            <= '0;
      num_misses          <= '0;
    end else begin
      bus.is_output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req.tag   <= bus.addr[31:4+IDX_W];
            req.idx   <= bus.addr[4+IDX_W-1:4];
            req.word  <= bus.addr[3:2];
            req.wr    <= bus.mem_write;   // store wins when both are set
            req.wdata <= bus.din;
            first     <= 1'b1;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          first <= 1'b0;
          if (first) begin
            if (hit) num_hits   <= num_hits + 32'd1;
            else     num_misses <= num_misses + 32'd1;
          end
          if (hit) begin
            bus.is_output_valid <= 1'b1;
            bus.is_hit          <= first;
            if (req.wr) dirty[req.idx] <= 1'b1;
            else        bus.dout       <= line_word;
            state <= IDLE;
          end else if (dirty[req.idx]) begin
            state <= WRITEBACK;
          end else begin
            state <= ALLOCATE;
          end
        end
        // Each memory state raises its own request on entry, so mem_req is
        // low for a cycle between a writeback ack and the following refill.
        WRITEBACK: begin
          if (!bus.mem_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {tags[req.idx], req.idx, 4'b0};
            bus.mem_wdata <= data[req.idx];
          end else if (bus.mem_ack) begin
            bus.mem_req    <= 1'b0;
            dirty[req.idx] <= 1'b0;
            state          <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (!bus.mem_req) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= {req.tag, req.idx, 4'b0};
          end else if (bus.mem_ack) begin
            bus.mem_req    <= 1'b0;
            valid[req.idx] <= 1'b1;
            dirty[req.idx] <= 1'b0;
            state          <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] num_hits, num_misses;

  data_cache_if #(.LINE_BITS(128)) bus ();

  data_cache #(.NUM_SETS(16), .LINE_BITS(128)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .num_hits(num_hits), .num_misses(num_misses)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- backing memory model ----------------
  logic [127:0] bmem [int unsigned];
  int           force_lat = -1;
  bit           mbusy = 0;
  int           mwait = 0;
  int           wb_cnt = 0, rf_cnt = 0;
  logic [31:0]  last_wb_addr = '0, last_rf_addr = '0;
  logic [127:0] last_wb_data = '0;

  function automatic logic [31:0] dflt_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = dflt_word(la + 32'(k * 4));
    return l;
  endfunction

  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (reset || !bus.mem_req) begin
      mbusy = 0;
    end else begin
      chk("ready_low_while_req", bus.is_ready, 1'b0);
      if (!mbusy) begin
        mbusy = 1;
        mwait = (force_lat >= 0) ? force_lat : int'($urandom_range(8, 0));
      end
      if (mwait == 0) begin
        bus.mem_ack = 1'b1;
        chk("mem_addr_align", bus.mem_addr[3:0], 4'h0);
        if (bus.mem_we) begin
          bmem[bus.mem_addr] = bus.mem_wdata;
          wb_cnt++;
          last_wb_addr = bus.mem_addr;
          last_wb_data = bus.mem_wdata;
        end else begin
          bus.mem_rdata = mem_line(bus.mem_addr);
          rf_cnt++;
          last_rf_addr = bus.mem_addr;
        end
      end else begin
        mwait--;
      end
    end
  end

  // ---------------- reference model (architectural view) ----------------
  logic [31:0] refw [int unsigned];   // every word the CPU has stored
  logic [27:0] rl [16];               // line address resident in each set
  bit          rv [16];
  bit          rdty [16];
  int          exp_hits = 0, exp_misses = 0;
  logic [31:0] last_load = '0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [127:0] l;
    wa = {a[31:2], 2'b00};
    if (refw.exists(wa)) return refw[wa];
    l = mem_line({a[31:4], 4'h0});
    return l[{a[3:2], 5'd0} +: 32];
  endfunction

  // Dirty lines die with a reset: the architectural view falls back to memory.
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin rv[i] = 0; rdty[i] = 0; end
    exp_hits = 0; exp_misses = 0; last_load = '0;
    refw.delete();
  endtask

  task automatic clear_inputs();
    bus.is_input_valid = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.addr = '0; bus.din = '0;
  endtask

  // Issue one request and wait for its completion. While the cache is busy the
  // inputs carry junk requests, which must be ignored.
  task automatic cpu_op(input bit rd_b, input bit wr_b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got_d,
                        output logic got_h, output int lat, output bit ok);
    ok = 0; lat = 0; got_d = '0; got_h = 1'b0;
    @(negedge clk);
    chk("ready_before_op", bus.is_ready, 1'b1);
    bus.is_input_valid = 1'b1; bus.addr = a; bus.din = d;
    bus.mem_read = rd_b; bus.mem_write = wr_b;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 200 && !ok; i++) begin
      bus.is_input_valid = 1'b1; bus.mem_read = 1'b1;
      bus.mem_write = 1'($urandom_range(1, 0));
      bus.addr = $urandom; bus.din = $urandom;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.is_output_valid) begin
        ok = 1; got_d = bus.dout; got_h = bus.is_hit;
        clear_inputs();
      end
    end
    if (!ok) clear_inputs();
  endtask

  task automatic run_op(input bit rd_b, input bit wr_b, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] got_d, exp_d;
    logic        got_h;
    int          lat, s, wb0, rf0;
    bit          ok, exp_h, exp_wb;
    s = int'(a[7:4]);
    wb0 = wb_cnt; rf0 = rf_cnt;
    exp_h  = rv[s] && (rl[s] == a[31:4]);
    exp_wb = !exp_h && rv[s] && rdty[s];
    if (exp_h) exp_hits++; else exp_misses++;
    if (!exp_h) begin rl[s] = a[31:4]; rv[s] = 1; rdty[s] = 0; end
    exp_d = wr_b ? last_load : ref_word(a);
    cpu_op(rd_b, wr_b, a, d, got_d, got_h, lat, ok);
    chk("completed", ok, 1'b1);
    chk("is_hit", got_h, exp_h);
    chk(wr_b ? "dout_held_on_store" : "load_data", got_d, exp_d);
    if (exp_h) chk("hit_latency", lat, 1);
    chk("num_hits", num_hits, exp_hits);
    chk("num_misses", num_misses, exp_misses);
    chk("writebacks", wb_cnt - wb0, exp_wb ? 1 : 0);
    chk("refills", rf_cnt - rf0, exp_h ? 0 : 1);
    if (wr_b) begin refw[{a[31:2], 2'b00}] = d; rdty[s] = 1; end
    else last_load = exp_d;
  endtask

  initial begin
    bit found;
    logic [31:0] a;
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #12;
    chk("rst_is_ready", bus.is_ready, 1'b1);
    chk("rst_out_valid", bus.is_output_valid, 1'b0);
    chk("rst_is_hit", bus.is_hit, 1'b0);
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
    chk("rst_counters", {num_hits, num_misses}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // cold load, hit in same line, store/load hits, conflicting tag eviction
    run_op(1, 0, 32'h100, 0);
    run_op(1, 0, 32'h104, 0);
    run_op(0, 1, 32'h108, 32'hDEAD_BEEF);
    run_op(1, 0, 32'h108, 0);
    run_op(1, 0, 32'h208, 0);
    chk("t4_wb_addr", last_wb_addr, 32'h100);
    chk("t4_wb_word2", last_wb_data[95:64], 32'hDEAD_BEEF);
    chk("t4_refill_addr", last_rf_addr, 32'h200);
    run_op(1, 0, 32'h108, 0);

    // request with neither op bit set produces nothing
    @(negedge clk);
    bus.is_input_valid = 1'b1; bus.addr = 32'h104;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.is_output_valid || !bus.is_ready) found = 1;
    end
    clear_inputs();
    chk("no_op_ignored", found, 1'b0);

    // both op bits set: the store wins
    run_op(1, 1, 32'h10C, 32'h1234_5678);
    run_op(1, 0, 32'h10C, 0);

    // random traffic over 4 tags x 16 sets to force conflicts and writebacks
    for (int n = 0; n < 400; n++) begin
      a = {22'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)), 2'b00};
      if ($urandom_range(1, 0) == 1) run_op(0, 1, a, $urandom);
      else                           run_op(1, 0, a, 0);
    end

    // reset while a refill is outstanding
    force_lat = 8;
    @(negedge clk);
    bus.is_input_valid = 1'b1; bus.mem_read = 1'b1; bus.addr = 32'h5000_0040;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_we) found = 1;
    end
    chk("t6_alloc_seen", found, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_mem_req_async", bus.mem_req, 1'b0);
    chk("t6_is_ready", bus.is_ready, 1'b1);
    chk("t6_counters", {num_hits, num_misses}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    force_lat = -1;
    model_reset();
    run_op(1, 0, 32'h5000_0040, 0);
    run_op(1, 0, 32'h5000_0044, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
